fir_input_sequencer: RTL and testbench

//  Upstream stage of the FIR filter datapath. On a start pulse, reads NUM_SAMPLES input samples from a

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_skid_fifo.sv | 49 ++++
 rtl/fir_input_sequencer.sv | 134 +++++++++++++
 tb/tb_fir_input_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR datapath stages.
package fir_pkg;

  localparam int unsigned FIR_DATA_W      = 12;
  localparam int unsigned FIR_ADDR_W      = 8;
  localparam int unsigned FIR_NUM_SAMPLES = 256;
  localparam int unsigned FIR_TAPS        = 6;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StFlush,
    StDrain
  } fir_seq_state_e;

endpackage

// File: rtl/fir_skid_fifo.sv
// Two-entry FIFO with registered storage; pop data is the head entry, valid while !empty.
module fir_skid_fifo #(
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == 2'd0);
  assign full     = (count_q == 2'd2);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fir_input_sequencer.sv
// Reads a block of samples from input memory, streams them to the FIR core and appends
// TAPS-1 zero samples to flush the tap delay line.
module fir_input_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W      = FIR_DATA_W,
  parameter int unsigned ADDR_W      = FIR_ADDR_W,
  parameter int unsigned NUM_SAMPLES = FIR_NUM_SAMPLES,
  parameter int unsigned TAPS        = FIR_TAPS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned FLUSH_W = (TAPS > 2) ? $clog2(TAPS - 1) : 1;
  localparam bit          HAS_FLUSH = (TAPS > 1);
  localparam logic [CNT_W-1:0]   RD_LAST    = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'((TAPS > 1) ? TAPS - 2 : 0);

  fir_seq_state_e     state_q, state_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic               rif_q, rif_last_q;
  logic               done_q, done_d;
  logic               issue, issue_last, flush_push, flush_last;
  logic [1:0]         occupancy;
  logic               fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [1:0]         fifo_count;
  logic [DATA_W:0]    fifo_wdata, fifo_rdata;

  // Throttle on registered state only, so out_ready never reaches mem_rd_en.
  assign occupancy = fifo_count + {1'b0, rif_q};

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    issue_last  = 1'b0;
    flush_push  = 1'b0;
    flush_last  = 1'b0;
    unique case (state_q)
      StIdle:  issue = start && !done_q;
      StRead:  issue = (occupancy < 2'd2);
      StFlush: begin
        // Zeros queue behind any read still in flight.
        if (!rif_q && !fifo_full) begin
          flush_push = 1'b1;
          if (flush_cnt_q == FLUSH_LAST) begin
            flush_last = 1'b1;
            state_d    = StDrain;
          end else begin
            flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
          end
        end
      end
      StDrain: begin
        if (fifo_pop && fifo_rdata[DATA_W]) begin
          done_d      = 1'b1;
          state_d     = StIdle;
          rd_cnt_d    = '0;
          flush_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (issue) begin
      if (rd_cnt_q == RD_LAST) begin
        issue_last = 1'b1;
        state_d    = HAS_FLUSH ? StFlush : StDrain;
      end else begin
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
        state_d  = StRead;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rd_cnt_q    <= '0;
      flush_cnt_q <= '0;
      rif_q       <= 1'b0;
      rif_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      rif_q       <= issue;
      rif_last_q  <= issue && issue_last && !HAS_FLUSH;
      done_q      <= done_d;
    end
  end

  assign fifo_push  = rif_q || flush_push;
  assign fifo_wdata = rif_q ? {rif_last_q, mem_rdata} : {flush_last, {DATA_W{1'b0}}};
  assign fifo_pop   = out_valid && out_ready;

  fir_skid_fifo #(
    .WIDTH(DATA_W + 1)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(fifo_wdata),
    .pop      (fifo_pop),
    .pop_data (fifo_rdata),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign mem_rd_en = issue;
  assign mem_addr  = rd_cnt_q[ADDR_W-1:0];
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata[DATA_W-1:0];
  assign out_last  = out_valid && fifo_rdata[DATA_W];

endmodule

// File: tb/tb_fir_input_sequencer.sv
// Randomized self-checking bench for fir_input_sequencer against a beat-list reference model.
module tb_fir_input_sequencer;

  localparam int N  = 256;
  localparam int T  = 6;
  localparam int DW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, busy, done, rd_en, valid, last;
  logic          ready = 1'b0;
  logic [7:0]    addr;
  logic [DW-1:0] rdata, data;

  logic          s1, busy1, done1, rd1, valid1, last1;
  logic [7:0]    addr1;
  logic [DW-1:0] rdata1, data1;
  logic          s4, busy4, done4, rd4, valid4, last4;
  logic [7:0]    addr4;
  logic [DW-1:0] rdata4, data4;

  fir_input_sequencer #(.DATA_W(DW), .ADDR_W(8), .NUM_SAMPLES(N), .TAPS(T)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .mem_rd_en(rd_en),
    .mem_addr(addr), .mem_rdata(rdata), .out_valid(valid), .out_ready(ready),
    .out_data(data), .out_last(last)
  );

  fir_input_sequencer #(.DATA_W(DW), .ADDR_W(8), .NUM_SAMPLES(1), .TAPS(1)) dut_n1 (
    .clk(clk), .reset(reset), .start(s1), .busy(busy1), .done(done1), .mem_rd_en(rd1),
    .mem_addr(addr1), .mem_rdata(rdata1), .out_valid(valid1), .out_ready(1'b1),
    .out_data(data1), .out_last(last1)
  );

  fir_input_sequencer #(.DATA_W(DW), .ADDR_W(8), .NUM_SAMPLES(4), .TAPS(6)) dut_n4 (
    .clk(clk), .reset(reset), .start(s4), .busy(busy4), .done(done4), .mem_rd_en(rd4),
    .mem_addr(addr4), .mem_rdata(rdata4), .out_valid(valid4), .out_ready(1'b1),
    .out_data(data4), .out_last(last4)
  );

  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (rd_en) rdata  <= mem[addr];
    if (rd1)   rdata1 <= mem[addr1];
    if (rd4)   rdata4 <= mem[addr4];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: the run is the N memory samples followed by taps-1 zeros; last marks the final beat.
  function automatic logic [12:0] exp_beat(input int i, input int n, input int taps);
    logic [DW-1:0] d;
    d = (i < n) ? mem[i] : 12'h000;
    return {(i == n + taps - 2), d};
  endfunction

  logic [12:0] got_q[$];
  logic [12:0] q1[$];
  logic [12:0] q4[$];
  int issued, done_cnt, done_cyc, last_cyc, first_valid_cyc, busy_gap, start_cyc;
  int d1, d4, ready_mode;
  bit run_active, stall_prev;
  logic [12:0] prev_beat;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       ready = ($urandom_range(0, 99) >= 40);
      2:       ready = (cyc - start_cyc >= 20);
      default: ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_hold", 32'({valid, last, data}), 32'({1'b1, prev_beat}));
      if (rd_en) begin
        int acc_data;
        acc_data = (got_q.size() < N) ? got_q.size() : N;
        check("rd_addr", 32'(addr), 32'(issued));
        check("throttle", 32'((issued + 1 - acc_data) <= 2), 32'(1));
        issued++;
      end
      if (ready_mode == 2 && run_active && cyc == start_cyc + 19) begin
        check("stall_reads", 32'(issued), 32'(2));
        check("stall_valid", 32'({valid, data}), 32'({1'b1, mem[0]}));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (run_active && cyc > start_cyc && done_cnt == 0 && !busy) busy_gap++;
      if (valid && ready) begin
        got_q.push_back({last, data});
        if (last) last_cyc = cyc;
      end
      stall_prev = valid && !ready;
      prev_beat  = {last, data};
      if (valid1) q1.push_back({last1, data1});
      if (valid4) q4.push_back({last4, data4});
      if (done1) d1++;
      if (done4) d4++;
    end
  end

  task automatic clear_run();
    got_q.delete();
    issued = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
    first_valid_cyc = -1; busy_gap = 0; run_active = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    start_cyc  = cyc;
    run_active = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k = 0;
    while (done_cnt == 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'(1));
    repeat (3) @(posedge clk);
  endtask

  task automatic check_run(input string tag);
    check({tag, "_beats"}, 32'(got_q.size()), 32'(N + T - 1));
    for (int i = 0; i < got_q.size() && i < N + T - 1; i++)
      check({tag, "_beat"}, 32'(got_q[i]), 32'(exp_beat(i, N, T)));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'(1));
    check({tag, "_done_lat"}, 32'(done_cyc - last_cyc), 32'(1));
    check({tag, "_first_valid"}, 32'(first_valid_cyc - start_cyc), 32'(2));
    check({tag, "_busy"}, 32'(busy_gap), 32'(0));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; s1 = 1'b0; s4 = 1'b0; ready_mode = 0;
    d1 = 0; d4 = 0;
    for (int i = 0; i < 256; i++) mem[i] = 12'(i);
    clear_run();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'({busy, done, rd_en, valid, last, addr, data}), 32'(0));
    check("reset_small", 32'({busy1, done1, valid1, last1, busy4, done4, valid4, last4}), 32'(0));
    @(negedge clk) reset = 1'b1;

    // Identity memory, ready high.
    pulse_start();
    wait_done("t1", 3000);
    check_run("t1");

    // Random data, random backpressure.
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
    clear_run(); ready_mode = 1;
    pulse_start();
    wait_done("t2", 6000);
    check_run("t2");

    // Ready held low for 20 cycles from start.
    clear_run(); ready_mode = 2;
    pulse_start();
    wait_done("t6", 3000);
    check_run("t6");

    // Stray starts while busy and in the done cycle.
    clear_run(); ready_mode = 0;
    pulse_start();
    for (int j = 0; j < 2; j++) begin
      repeat (15 + $urandom_range(0, 40)) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    begin
      int k = 0;
      while (!(valid && ready && last) && k < 3000) begin
        @(negedge clk);
        k++;
      end
      check("t3_last_seen", 32'(valid && ready && last), 32'(1));
    end
    @(posedge clk);
    #1 start = 1'b1;
    check("t3_done_cycle", 32'(done), 32'(1));
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("t3_no_rerun", 32'({busy, rd_en}), 32'(0));
    check("t3_reads", 32'(issued), 32'(N));
    check_run("t3a");
    clear_run();
    pulse_start();
    wait_done("t3b", 3000);
    check_run("t3b");

    // Asynchronous reset after beat 100.
    clear_run();
    pulse_start();
    begin
      int k = 0;
      while (got_q.size() < 100 && k < 3000) begin
        @(negedge clk);
        k++;
      end
      check("t4_reached_100", 32'(got_q.size() >= 100), 32'(1));
    end
    #2 reset = 1'b0;
    #1;
    check("t4_reset_outs", 32'({busy, done, rd_en, valid, last, addr, data}), 32'(0));
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (20) @(posedge clk);
    check("t4_no_done", 32'(done_cnt), 32'(0));
    clear_run();
    pulse_start();
    wait_done("t4", 3000);
    check_run("t4");

    // Small configurations.
    q1.delete(); q4.delete(); d1 = 0; d4 = 0;
    @(posedge clk);
    #1 begin s1 = 1'b1; s4 = 1'b1; end
    @(posedge clk);
    #1 begin s1 = 1'b0; s4 = 1'b0; end
    repeat (60) @(posedge clk);
    check("n1_beats", 32'(q1.size()), 32'(1));
    if (q1.size() > 0) check("n1_beat", 32'(q1[0]), 32'(exp_beat(0, 1, 1)));
    check("n1_done", 32'(d1), 32'(1));
    check("n4_beats", 32'(q4.size()), 32'(9));
    for (int i = 0; i < q4.size() && i < 9; i++)
      check("n4_beat", 32'(q4[i]), 32'(exp_beat(i, 4, 6)));
    check("n4_done", 32'(d4), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
